// File: rtl/sigma_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sigma_io_pkg
//  Brief    : Shared codes for the Sigma I/O card peripherals (reader/punch):
//             condition codes, default card geometry and the punch state enum.
//  Revision : 1.0  initial release
// ============================================================================
package sigma_io_pkg;

  // Condition codes returned in cc after a TIO
  localparam logic [3:0] CC_SIO_OK = 4'd0;
  localparam logic [3:0] CC_BUSY   = 4'd6;

  // Default card geometry and buffer origin
  localparam int unsigned WORDS_PER_CARD         = 30;
  localparam logic [16:0] BUFFER_ADDRESS_DEFAULT = 17'h0002a;

  // Punch sequencing states; the reader can adopt the same encoding
  typedef enum logic [1:0] {
    PUNCH_IDLE = 2'd0,
    PUNCH_REQ  = 2'd1,
    PUNCH_CAPT = 2'd2,
    PUNCH_PUSH = 2'd3
  } punch_state_t;

  // Word addresses wrap modulo 2^17
  function automatic logic [16:0] next_word_address(input logic [16:0] addr);
    return addr + 17'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_punch.sv
`default_nettype none
// ============================================================================
//  Module   : card_punch
//  Brief    : Sigma I/O card punch. On SIO it reads one card image of
//             WORDS_PER_CARD words from main memory over the IOP port and
//             hands each word to the punch sink over valid/ready, flagging
//             the last word. One word is held at a time (no FIFO).
//  Revision : 1.0  initial release
// ============================================================================
module card_punch
  import sigma_io_pkg::*;
#(
  parameter int unsigned WORDS_PER_CARD = sigma_io_pkg::WORDS_PER_CARD,
  parameter logic [16:0] BUFFER_ADDRESS = BUFFER_ADDRESS_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,          // asynchronous, active-low
  input  logic         sio,
  input  logic         tio,
  output logic [0:3]   cc,
  output logic         running,
  input  logic         active,
  output logic         rd_enable,
  output logic [15:31] memory_address,
  input  logic [0:31]  memory_data_in,
  output logic [0:31]  punch_data,
  output logic         punch_valid,
  output logic         punch_last,
  input  logic         punch_ready
);

  // Card length as loaded into the 8-bit word counter
  localparam logic [7:0] c_card_words = 8'(WORDS_PER_CARD);

  punch_state_t r_state;
  punch_state_t w_state_next;

  logic [7:0]  r_word_count;
  logic [16:0] r_address;
  logic [31:0] r_punch_data;
  logic [3:0]  r_cc;

  logic w_start;     // SIO accepted this cycle
  logic w_capture;   // granted read data is on memory_data_in this cycle
  logic w_count_zero;

  assign w_count_zero = (r_word_count == 8'd0);
  assign w_start      = (r_state == PUNCH_IDLE) && sio;
  assign w_capture    = (r_state == PUNCH_CAPT);

  // State register; reset abandons any partial card immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= PUNCH_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: one word per REQ -> CAPT -> PUSH round trip
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PUNCH_IDLE: begin
        if (sio) begin
          w_state_next = PUNCH_REQ;
        end
      end
      PUNCH_REQ: begin
        // Hold the request until the IOP grants the memory port
        if (active) begin
          w_state_next = PUNCH_CAPT;
        end
      end
      PUNCH_CAPT: begin
        w_state_next = PUNCH_PUSH;
      end
      PUNCH_PUSH: begin
        // Back-pressure holds the word here; no read is issued meanwhile
        if (punch_ready) begin
          w_state_next = w_count_zero ? PUNCH_IDLE : PUNCH_REQ;
        end
      end
      default: begin
        w_state_next = PUNCH_IDLE;
      end
    endcase
  end

  // Word counter: loaded on SIO, counts captured words, saturates at zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_word_count <= 8'd0;
    end else if (w_start) begin
      r_word_count <= c_card_words;
    end else if (w_capture && !w_count_zero) begin
      r_word_count <= r_word_count - 8'd1;
    end
  end

  // Fetch address persists across cards; only reset rewinds it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_address <= BUFFER_ADDRESS;
    end else if (w_capture) begin
      r_address <= next_word_address(r_address);
    end
  end

  // Holding register for the word being punched; stable through PUSH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_punch_data <= 32'd0;
    end else if (w_capture) begin
      r_punch_data <= memory_data_in;
    end
  end

  // Condition code sampled every cycle from the pre-edge state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cc <= CC_SIO_OK;
    end else if (tio && (r_state == PUNCH_IDLE)) begin
      r_cc <= CC_SIO_OK;
    end else begin
      r_cc <= CC_BUSY;
    end
  end

  // Handshake outputs decode registered state only
  assign running        = (r_state != PUNCH_IDLE);
  assign rd_enable      = (r_state == PUNCH_REQ);
  assign punch_valid    = (r_state == PUNCH_PUSH);
  assign punch_last     = (r_state == PUNCH_PUSH) && w_count_zero;
  assign memory_address = r_address;
  assign punch_data     = r_punch_data;
  assign cc             = r_cc;

endmodule
`default_nettype wire

// File: tb/tb_card_punch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_card_punch
//  Brief    : Randomized scoreboard bench for card_punch. A memory model
//             returns a hash of each read address; expected card images are
//             queued at SIO and popped by a monitor on each accepted word.
//  Revision : 1.0  initial release
// ============================================================================
module tb_card_punch;

  localparam int          W    = 30;
  localparam logic [16:0] BUF  = 17'h0002a;
  localparam int          W2   = 4;
  localparam logic [16:0] BUF2 = 17'h1fffe;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         sio, tio, active, punch_ready;
  logic [0:3]   cc;
  logic         running, rd_enable, punch_valid, punch_last;
  logic [15:31] memory_address;
  logic [0:31]  memory_data_in, punch_data;

  logic         sio2, tio2, active2, ready2;
  logic [0:3]   cc2;
  logic         running2, rd2, pv2, pl2;
  logic [15:31] addr2;
  logic [0:31]  mem2, pd2;

  int n_vec = 0;
  int n_err = 0;

  exp_t        sb_q[$];
  logic [16:0] q2_addr[$];
  logic [16:0] model_card_addr;
  logic [16:0] model_rd_addr;
  int          word_idx;
  int          stall_left;
  bit          active_rand, ready_rand;
  bit          rd_pend, have_hold, pend2;
  logic [16:0] rd_pend_addr, pend2_addr;
  logic [31:0] held_data;

  card_punch dut (
    .clock(clock), .reset(reset), .sio(sio), .tio(tio), .cc(cc),
    .running(running), .active(active), .rd_enable(rd_enable),
    .memory_address(memory_address), .memory_data_in(memory_data_in),
    .punch_data(punch_data), .punch_valid(punch_valid),
    .punch_last(punch_last), .punch_ready(punch_ready)
  );

  card_punch #(.WORDS_PER_CARD(W2), .BUFFER_ADDRESS(BUF2)) dut2 (
    .clock(clock), .reset(reset), .sio(sio2), .tio(tio2), .cc(cc2),
    .running(running2), .active(active2), .rd_enable(rd2),
    .memory_address(addr2), .memory_data_in(mem2),
    .punch_data(pd2), .punch_valid(pv2),
    .punch_last(pl2), .punch_ready(ready2)
  );

  always #5 clock = ~clock;

  // Memory contents: an odd-multiplier hash, so every address is distinct
  function automatic logic [31:0] mem_word(input logic [16:0] a);
    return ({15'd0, a} * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder, read-address model and punch-side monitor
  always @(negedge clock) begin
    if (!reset) begin
      sb_q.delete();
      word_idx      = 0;
      rd_pend       = 0;
      have_hold     = 0;
      model_rd_addr = BUF;
      active        = 1'b1;
      punch_ready   = 1'b1;
      memory_data_in = 32'd0;
    end else begin
      memory_data_in = rd_pend ? mem_word(rd_pend_addr) : $urandom;
      rd_pend = 0;
      active  = active_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_enable && active) begin
        check("read_address", 64'(memory_address), 64'(model_rd_addr));
        model_rd_addr = model_rd_addr + 17'd1;
        rd_pend       = 1;
        rd_pend_addr  = memory_address;
      end
      if (rd_enable && punch_valid) check("read_while_holding", 64'(rd_enable), 64'd0);
      if (stall_left > 0 && punch_valid && word_idx == 4) begin
        punch_ready = 1'b0;
        stall_left--;
      end else begin
        punch_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (punch_valid) begin
        if (have_hold) check("held_data_stable", 64'(punch_data), 64'(held_data));
        if (punch_ready) begin
          have_hold = 0;
          if (sb_q.size() == 0) begin
            check("unexpected_word", 64'(punch_data), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("punch_data", 64'(punch_data), 64'(e.data));
            check("punch_last", 64'(punch_last), 64'(e.last));
            word_idx = e.last ? 0 : word_idx + 1;
          end
        end else begin
          have_hold = 1;
          held_data = punch_data;
        end
      end
    end
  end

  // Memory responder for the wrap-around instance; logs read addresses
  always @(negedge clock) begin
    if (!reset) begin
      pend2 = 0;
      q2_addr.delete();
      mem2 = 32'd0;
    end else begin
      mem2  = pend2 ? mem_word(pend2_addr) : $urandom;
      pend2 = 0;
      if (rd2 && active2) begin
        pend2      = 1;
        pend2_addr = addr2;
        q2_addr.push_back(addr2);
      end
    end
  end

  // Issue an SIO pulse and queue the expected card image
  task automatic start_card(input bit with_tio);
    @(negedge clock);
    sio = 1'b1;
    tio = with_tio;
    for (int i = 0; i < W; i++) begin
      exp_t e;
      e.data = mem_word(model_card_addr + 17'(i));
      e.last = (i == W - 1);
      sb_q.push_back(e);
    end
    model_card_addr = model_card_addr + 17'(W);
    @(negedge clock);
    sio = 1'b0;
    tio = 1'b0;
  endtask

  // Wait for the card to finish; returns the negedge index where running fell
  task automatic wait_idle(input int budget, output int idx);
    idx = 1;
    while (running && idx < budget) begin
      @(negedge clock);
      idx++;
    end
    check("card_done_in_budget", 64'(running), 64'd0);
  endtask

  initial begin
    int idx, first_pv, k;
    logic [31:0] got_d[W2];
    logic        got_l[W2];
    logic [16:0] exp2[W2];

    reset = 1'b0; sio = 1'b0; tio = 1'b0;
    sio2 = 1'b0; tio2 = 1'b0; active2 = 1'b1; ready2 = 1'b1;
    active_rand = 0; ready_rand = 0; stall_left = 0;
    model_card_addr = BUF;
    exp2[0] = 17'h1fffe; exp2[1] = 17'h1ffff; exp2[2] = 17'h00000; exp2[3] = 17'h00001;

    repeat (3) @(negedge clock);
    check("rst_running", 64'(running), 64'd0);
    check("rst_rd_enable", 64'(rd_enable), 64'd0);
    check("rst_punch_valid", 64'(punch_valid), 64'd0);
    check("rst_punch_last", 64'(punch_last), 64'd0);
    check("rst_punch_data", 64'(punch_data), 64'd0);
    check("rst_cc", 64'(cc), 64'd0);
    check("rst_address", 64'(memory_address), 64'(BUF));
    check("rst_address_dut2", 64'(addr2), 64'(BUF2));
    #2 reset = 1'b1;

    // Card 1: full-rate timing with active and ready held high
    start_card(1'b0);
    check("running_after_sio", 64'(running), 64'd1);
    check("rd_enable_after_sio", 64'(rd_enable), 64'd1);
    idx = 1; first_pv = 0;
    while (running && idx < 400) begin
      @(negedge clock);
      idx++;
      if (punch_valid && first_pv == 0) first_pv = idx;
    end
    check("first_punch_valid_cycle", 64'(first_pv), 64'd3);
    check("card_length_cycles", 64'(idx), 64'(3 * W + 1));
    check("address_after_card1", 64'(memory_address), 64'h48);
    check("queue_empty_card1", 64'(sb_q.size()), 64'd0);

    // Card 2: stray SIO/TIO mid-card, TIO on the edge returning to IDLE
    start_card(1'b0);
    idx = 1;
    while (idx < 400) begin
      @(negedge clock);
      idx++;
      if (idx == 20) begin sio = 1'b1; tio = 1'b1; end
      if (idx == 21) begin
        sio = 1'b0; tio = 1'b0;
        check("cc_busy_mid_card", 64'(cc), 64'd6);
      end
      if (punch_valid && punch_last) break;
    end
    check("last_word_cycle", 64'(idx), 64'(3 * W));
    tio = 1'b1;
    @(negedge clock);
    check("cc_on_return_edge", 64'(cc), 64'd6);
    check("idle_after_card2", 64'(running), 64'd0);
    @(negedge clock);
    tio = 1'b0;
    check("cc_tio_idle", 64'(cc), 64'd0);
    check("address_after_card2", 64'(memory_address), 64'h66);
    check("queue_empty_card2", 64'(sb_q.size()), 64'd0);

    // Card 3: SIO together with TIO, then a 10-cycle stall on word 5
    stall_left = 10;
    start_card(1'b1);
    check("cc_sio_with_tio", 64'(cc), 64'd0);
    wait_idle(600, idx);
    check("stall_consumed", 64'(stall_left), 64'd0);
    check("queue_empty_card3", 64'(sb_q.size()), 64'd0);

    // Card 4: random grant and random back-pressure
    active_rand = 1; ready_rand = 1;
    start_card(1'b0);
    wait_idle(3000, idx);
    check("queue_empty_card4", 64'(sb_q.size()), 64'd0);
    active_rand = 0; ready_rand = 0;

    // Card 5: reset pulsed mid-card around word 12
    start_card(1'b0);
    idx = 0;
    while (word_idx < 11 && idx < 400) begin
      @(negedge clock);
      idx++;
    end
    check("reached_word_12", 64'(word_idx), 64'd11);
    #2 reset = 1'b0;
    #1;
    check("async_rst_punch_valid", 64'(punch_valid), 64'd0);
    check("async_rst_running", 64'(running), 64'd0);
    check("async_rst_rd_enable", 64'(rd_enable), 64'd0);
    check("async_rst_address", 64'(memory_address), 64'(BUF));
    check("async_rst_punch_data", 64'(punch_data), 64'd0);
    model_card_addr = BUF;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;

    // Card 6: restart from the buffer origin
    start_card(1'b0);
    wait_idle(400, idx);
    check("address_after_restart", 64'(memory_address), 64'h48);
    check("queue_empty_card6", 64'(sb_q.size()), 64'd0);

    // Wrap-around instance: 4 words from 1fffe
    @(negedge clock);
    sio2 = 1'b1;
    @(negedge clock);
    sio2 = 1'b0;
    k = 0;
    for (int c = 0; c < 60 && k < W2; c++) begin
      if (pv2) begin
        got_d[k] = pd2;
        got_l[k] = pl2;
        k++;
      end
      @(negedge clock);
    end
    check("dut2_word_count", 64'(k), 64'(W2));
    check("dut2_read_count", 64'(q2_addr.size()), 64'(W2));
    for (int i = 0; i < W2 && i < k; i++) begin
      if (q2_addr.size() > 0) check("dut2_read_address", 64'(q2_addr.pop_front()), 64'(exp2[i]));
      check("dut2_punch_data", 64'(got_d[i]), 64'(mem_word(exp2[i])));
      check("dut2_punch_last", 64'(got_l[i]), 64'(i == W2 - 1));
    end
    check("dut2_address_wrapped", 64'(addr2), 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/card_punch.md
# card_punch

Output peripheral for the Sigma I/O model, and the other direction of the card reader. After a start I/O (SIO), it fetches one card image of WORDS_PER_CARD 32-bit words from main memory over the IOP memory port. Each word goes to a punch-side sink over a valid/ready handshake, with the last word of the card flagged. It sits beside the card reader on the same IOP `active` grant and sio/tio/cc status path.

## Interface
- WORDS_PER_CARD, 30, words fetched and punched per SIO (1..255)
- BUFFER_ADDRESS, 17'h2a, word address of first fetch after reset
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- sio  in  1  start I/O pulse; begins a card when idle
- tio  in  1  test I/O pulse; requests status in cc
- cc  out  [0:3]  condition code: 0 = SIO possible, 6 = busy
- running  out  1  high whenever a card is in progress
- active  in  1  IOP memory grant; a read is performed in a cycle where rd_enable and active are both high
- rd_enable  out  1  memory read request
- memory_address  out  [15:31]  word address of current read (registered)
- memory_data_in  in  [0:31]  read data, valid the cycle after the granted read
- punch_data  out  [0:31]  word to punch (registered)
- punch_valid  out  1  punch_data valid
- punch_last  out  1  qualifies punch_valid: final word of card
- punch_ready  in  1  sink accepts word when high with punch_valid

## Operation
- State register: IDLE, REQ, CAPT, PUSH.
- rd_enable, punch_valid, punch_last and running are decoded from registered state/counter only. There is no combinational path from any input.
- IDLE:
  - sio loads word_count = WORDS_PER_CARD and moves to REQ.
- REQ:
  - rd_enable = 1.
  - When active = 1, move to CAPT.
- CAPT:
  - punch_data <= memory_data_in.
  - memory_address <= memory_address + 1.
  - word_count <= word_count - 1.
  - Move to PUSH.
- PUSH:
  - punch_valid = 1.
  - punch_last = (word_count == 0).
  - On punch_ready, go to IDLE if word_count == 0, else to REQ.
  - punch_data is held stable until accepted.
- running = (state != IDLE).
- cc is registered every cycle.
  - tio with state == IDLE gives cc <= 0.
  - Otherwise cc <= 6.
  - cc is evaluated on the pre-edge state.
- memory_address persists across cards. Consecutive SIOs punch consecutive memory blocks. It is reloaded to BUFFER_ADDRESS only by reset.
- Arithmetic:
  - memory_address is 17 bits, modulo 2^17; 17'h1ffff + 1 = 0.
  - word_count is 8 bits and never decrements below 0.

## Timing
- Reset values:
  - state IDLE, running 0, rd_enable 0
  - punch_valid 0, punch_last 0, punch_data 0
  - cc 0, word_count 0
  - memory_address BUFFER_ADDRESS
- SIO accepted at edge N gives running = 1 and rd_enable = 1 from cycle N+1.
- Minimum 3 cycles per word: REQ with active already high, then CAPT, then PUSH with punch_ready high.
  - Card minimum: 3*WORDS_PER_CARD cycles from SIO to return to IDLE.
- First punch_valid appears 3 cycles after the SIO edge when active and punch_ready are held high.
- Back-pressure: punch_ready low holds PUSH indefinitely. No further memory reads occur, so there is at most one word in flight.
- Boundary conditions:
  - sio while running is ignored: no reload, card continues.
  - sio and tio in the same IDLE cycle: SIO accepted, cc <= 0.
  - tio on the same edge the block returns to IDLE (punch_last accepted): cc <= 6; the next tio returns 0.
  - active low in REQ: wait, rd_enable stays high, address stable.
  - reset asserted mid-card: partial card abandoned, punch_valid drops immediately, address returns to BUFFER_ADDRESS.

## Structure
- Shared package sigma_io_pkg:
  - CC_SIO_OK = 4'd0, CC_BUSY = 4'd6
  - default WORDS_PER_CARD
  - punch state enum, so the reader can be migrated to the same codes
- Single module, no sub-module. The one-word holding register is part of the PUSH state, not a FIFO.

## Test plan
- Reset, then SIO with active = 1 and punch_ready = 1 held high
  - 30 words from addresses 0x2a..0x47 emerge in order, each 3 cycles apart.
  - punch_last is set only on word 30.
  - running falls the cycle after acceptance.
  - memory_address = 0x48.
- Second SIO after the first card completes:
  - fetches 0x48..0x65 (address persistence)
- punch_ready low for 10 cycles on word 5:
  - punch_data is stable and rd_enable stays 0.
  - the remaining words are unchanged and in order.
- tio during a card gives cc = 6; tio after completion gives cc = 0.
  - SIO pulses mid-card leave word count and total card length at 30.
- active toggled pseudo-randomly:
  - reads occur only in cycles where rd_enable and active are both high.
  - no word is duplicated or skipped.
- Reset pulsed low at word 12:
  - all outputs at reset values asynchronously.
  - next SIO restarts at 0x2a.
- BUFFER_ADDRESS = 17'h1fffe, WORDS_PER_CARD = 4:
  - reads 1fffe, 1ffff, 0, 1.
